btn_event_arbiter: RTL and testbench
====================================

// Module: btn_event_arbiter
// PURPOSE
//  Controller for a bank of push buttons. Each button gets a oneshot press detector, extended with
//  hold-to-repeat. The block queues one pending event per button and shares a single event output
//  channel between all buttons through a round-robin arbiter with a valid/ready handshake.
//  It sits between the upstream synchronised/debounced button inputs and the event consumer.
// PARAMETERS
//  N_BTN     4     number of buttons (>=2)
//  HOLD_CYC  1000  cycles held after the press event before the first repeat event (>=2)
//  RPT_CYC   250   cycles between successive repeat events while still held (>=2)
//  ID_W      $clog2(N_BTN)  width of evt_id_o (derived, do not override)
// PORTS
//  clk_i        in   1      clock, all logic on posedge
//  rstn_i       in   1      synchronous reset, active low
//  btn_i        in   N_BTN  button levels, already synchronous to clk_i (1 = pressed)
//  evt_valid_o  out  1      event available on evt_id_o/evt_rpt_o
//  evt_ready_i  in   1      consumer accepts event when evt_valid_o & evt_ready_i
//  evt_id_o     out  ID_W   index of the button that produced the event
//  evt_rpt_o    out  1      0 = initial press event, 1 = auto-repeat event
//  ovf_o        out  1      sticky: an event was dropped (pending slot already full)
//  clr_ovf_i    in   1      clears ovf_o
// BEHAVIOUR
//  Reset: rstn_i=0 sampled -> all button FSMs IDLE, counters 0, pending clear, evt_valid_o=0,
//   evt_id_o=0, evt_rpt_o=0, ovf_o=0, last-grant pointer = N_BTN-1 (first scan starts at btn 0).
//   Reset mid-hold aborts the hold. A button still high after reset is treated as a new press.
//  Per-button FSM (counter cnt, width $clog2(max(HOLD_CYC,RPT_CYC))):
//   IDLE:   btn=1 -> ARM, cnt<=0, raise press event. btn=0 -> stay.
//   ARM:    btn=0 -> IDLE. Else if cnt==HOLD_CYC-1 -> RPT, cnt<=0, raise repeat event; else cnt++.
//   RPT:    btn=0 -> IDLE. Else if cnt==RPT_CYC-1 -> cnt<=0, raise repeat event; else cnt++.
//   Any unused encoding -> IDLE.
//   Release always wins over counter terminal on the same cycle (no event).
//  Pending slot per button (pend bit + rpt flag):
//   - A raised event sets pend and records the type.
//   - If pend is already set and not granted this cycle: drop the new event, set ovf_o,
//     and keep the old type.
//   - If the button is granted in the same cycle as a new event is raised: the new event occupies
//     the slot. This is not an overflow.
//  Output register / arbiter:
//   - Load condition: evt_valid_o==0 or (evt_valid_o & evt_ready_i).
//   - On load, scan pend round-robin from last_grant+1 (mod N_BTN). The first set bit is granted:
//     its id/type go to the outputs, evt_valid_o<=1, its pend is cleared, and last_grant<=id.
//   - If load and no pend bit is set: evt_valid_o<=0.
//   - While valid & !ready, evt_id_o/evt_rpt_o/evt_valid_o are held stable.
//   - Throughput: one event per cycle with evt_ready_i held at 1.
//  Latency: btn_i rise sampled at edge t -> pend set at t -> evt_valid_o=1 after edge t+1
//   (output idle). Repeat: first repeat pend at edge t+HOLD_CYC, then every RPT_CYC edges.
//  ovf_o: set on drop. clr_ovf_i clears it. Set wins when set and clear occur in the same cycle.
//  Multiple buttons rising in the same cycle: all pend bits set; granted in round-robin order.
// TESTING (N_BTN=4, HOLD_CYC=8, RPT_CYC=4 unless noted)
//  1 Reset: rstn_i=0 for 3 cycles with btn_i=4'b1111 -> outputs all 0. After release, 4 press
//    events (ids 0,1,2,3, rpt=0), one per cycle, with ready=1.
//  2 Tap: btn_i[2]=1 for 1 cycle, ready=1 -> exactly one event, id=2, rpt=0,
//    valid 2 edges after the rise. No repeat.
//  3 Hold: btn_i[1]=1 for edges 0..19, ready=1 -> press event at edge 0 (rpt=0), then rpt=1 events
//    pended at edges 8, 12 and 16. None after release.
//  4 Fairness: btn_i=4'b1011 rise together, ready=1 -> ids 0,1,3 in order. Repeat the rise with
//    last_grant=0 -> order 1,3,0.
//  5 Backpressure/overflow: ready=0, hold btn 0 past HOLD_CYC -> valid stays up with id=0, rpt=0
//    held. The first repeat pends. The second repeat sets ovf_o=1. Raise ready -> repeat event
//    delivered. Pulse clr_ovf_i -> ovf_o=0.
//  6 Simultaneous grant/raise: arrange a repeat raise on btn 3 in the same cycle its pend is
//    granted -> both events delivered, ovf_o stays 0.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// Push-button event controller: per-button press/hold-to-repeat FSM, one pending slot per
// button, and a round-robin arbiter feeding a single valid/ready event channel.
//
// state | meaning
// IDLE  | button released, waiting for a press
// ARM   | press reported, counting HOLD_CYC cycles toward the first repeat
// RPT   | auto-repeat active, one repeat event every RPT_CYC cycles
module btn_event_arbiter #(
  parameter int N_BTN    = 4,
  parameter int HOLD_CYC = 1000,
  parameter int RPT_CYC  = 250,
  localparam int ID_W    = $clog2(N_BTN)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [ID_W-1:0] evt_id_o,
  output logic            evt_rpt_o,
  output logic            ovf_o,
  input  logic            clr_ovf_i
);

  localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RPT  = 2'd2
  } state_e;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] raise;
  logic [N_BTN-1:0] raise_rpt;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] prpt_q, prpt_d;
  logic [N_BTN-1:0] gnt_oh;

  logic             valid_q;
  logic [ID_W-1:0]  id_q;
  logic             rpt_q;
  logic             ovf_q, ovf_d, ovf_set;
  logic [ID_W-1:0]  last_q;

  logic             load;
  logic             found;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  scan_idx;
  int               scan_pos;

  // Release is tested before the terminal count so it always wins.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      raise[i]     = 1'b0;
      raise_rpt[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (btn_i[i]) begin
            state_d[i] = S_ARM;
            cnt_d[i]   = '0;
            raise[i]   = 1'b1;
          end
        end
        S_ARM: begin
          if (!btn_i[i]) begin
            state_d[i] = S_IDLE;
          end else if (cnt_q[i] == CNT_W'(HOLD_CYC - 1)) begin
            state_d[i]   = S_RPT;
            cnt_d[i]     = '0;
            raise[i]     = 1'b1;
            raise_rpt[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_RPT: begin
          if (!btn_i[i]) begin
            state_d[i] = S_IDLE;
          end else if (cnt_q[i] == CNT_W'(RPT_CYC - 1)) begin
            cnt_d[i]     = '0;
            raise[i]     = 1'b1;
            raise_rpt[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  assign load = !valid_q || evt_ready_i;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      scan_pos = int'(last_q) + k;
      if (scan_pos >= N_BTN) scan_pos = scan_pos - N_BTN;
      scan_idx = scan_pos[ID_W-1:0];
      if (!found && pend_q[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (found && load) gnt_oh[gnt_idx] = 1'b1;
  end

  // A slot granted this cycle is free for a simultaneous raise; otherwise a full slot drops.
  always_comb begin
    pend_d  = pend_q;
    prpt_d  = prpt_q;
    ovf_set = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (gnt_oh[i]) begin
        pend_d[i] = raise[i];
        if (raise[i]) prpt_d[i] = raise_rpt[i];
      end else if (raise[i]) begin
        if (pend_q[i]) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          prpt_d[i] = raise_rpt[i];
        end
      end
    end
    if (ovf_set)        ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pend_q  <= '0;
      prpt_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      rpt_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= ID_W'(N_BTN - 1);
    end else begin
      pend_q <= pend_d;
      prpt_q <= prpt_d;
      ovf_q  <= ovf_d;
      if (load) begin
        if (found) begin
          valid_q <= 1'b1;
          id_q    <= gnt_idx;
          rpt_q   <= prpt_q[gnt_idx];
          last_q  <= gnt_idx;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_rpt_o   = rpt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with N_BTN=4, HOLD_CYC=8, RPT_CYC=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_btn_event_arbiter;

  localparam int N_BTN    = 4;
  localparam int HOLD_CYC = 8;
  localparam int RPT_CYC  = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [3:0] btn_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_id_o;
  logic       evt_rpt_o;
  logic       ovf_o;
  logic       clr_ovf_i;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  btn_event_arbiter #(
    .N_BTN   (N_BTN),
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .btn_i      (btn_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_id_o   (evt_id_o),
    .evt_rpt_o  (evt_rpt_o),
    .ovf_o      (ovf_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id, input logic r);
    chk({tag, ".valid"}, 32'(evt_valid_o), 32'(v));
    if (v) begin
      chk({tag, ".id"}, 32'(evt_id_o), 32'(id));
      chk({tag, ".rpt"}, 32'(evt_rpt_o), 32'(r));
    end
  endtask

  initial begin
    // reset with all buttons held
    rstn_i      = 1'b0;
    btn_i       = 4'b1111;
    evt_ready_i = 1'b1;
    clr_ovf_i   = 1'b0;
    repeat (3) tick();
    chk("rst.valid", 32'(evt_valid_o), 32'd0);
    chk("rst.id",    32'(evt_id_o),    32'd0);
    chk("rst.rpt",   32'(evt_rpt_o),   32'd0);
    chk("rst.ovf",   32'(ovf_o),       32'd0);
    rstn_i = 1'b1;
    tick(); chk_evt("rst.e0", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("rst.e1", 1'b1, 2'd0, 1'b0);
    tick(); chk_evt("rst.e2", 1'b1, 2'd1, 1'b0);
    tick(); chk_evt("rst.e3", 1'b1, 2'd2, 1'b0);
    tick(); chk_evt("rst.e4", 1'b1, 2'd3, 1'b0);
    btn_i = 4'b0000;
    tick(); chk_evt("rst.e5", 1'b0, 2'd0, 1'b0);

    // single-cycle tap on button 2
    btn_i = 4'b0100;
    tick(); chk_evt("tap.e0", 1'b0, 2'd0, 1'b0);
    btn_i = 4'b0000;
    tick(); chk_evt("tap.e1", 1'b1, 2'd2, 1'b0);
    for (int e = 2; e < 14; e++) begin
      tick(); chk_evt($sformatf("tap.e%0d", e), 1'b0, 2'd0, 1'b0);
    end

    // hold button 1 for edges 0..19; release coincides with a terminal count at edge 20
    btn_i = 4'b0010;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (e == 19) btn_i = 4'b0000;
      chk_evt($sformatf("hold.e%0d", e), (e == 1 || e == 9 || e == 13 || e == 17), 2'd1, (e != 1));
    end

    // fairness: fresh reset puts last_grant at 3
    rstn_i = 1'b0;
    btn_i  = 4'b0000;
    repeat (2) tick();
    chk("rst2.valid", 32'(evt_valid_o), 32'd0);
    rstn_i = 1'b1;
    btn_i  = 4'b1011;
    tick(); chk_evt("fair1.e0", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("fair1.e1", 1'b1, 2'd0, 1'b0);
    tick(); chk_evt("fair1.e2", 1'b1, 2'd1, 1'b0);
    tick(); chk_evt("fair1.e3", 1'b1, 2'd3, 1'b0);
    btn_i = 4'b0000;
    tick(); chk_evt("fair1.e4", 1'b0, 2'd0, 1'b0);
    btn_i = 4'b0001;
    tick(); chk_evt("tap0.e0", 1'b0, 2'd0, 1'b0);
    btn_i = 4'b0000;
    tick(); chk_evt("tap0.e1", 1'b1, 2'd0, 1'b0);
    tick(); chk_evt("tap0.e2", 1'b0, 2'd0, 1'b0);
    btn_i = 4'b1011;
    tick(); chk_evt("fair2.e0", 1'b0, 2'd0, 1'b0);
    tick(); chk_evt("fair2.e1", 1'b1, 2'd1, 1'b0);
    tick(); chk_evt("fair2.e2", 1'b1, 2'd3, 1'b0);
    tick(); chk_evt("fair2.e3", 1'b1, 2'd0, 1'b0);
    btn_i = 4'b0000;
    tick(); chk_evt("fair2.e4", 1'b0, 2'd0, 1'b0);

    // backpressure: press held in output, first repeat pends, second repeat drops
    evt_ready_i = 1'b0;
    btn_i       = 4'b0001;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 11) clr_ovf_i = 1'b1;
      if (e == 12) clr_ovf_i = 1'b0;
      chk_evt($sformatf("bp.e%0d", e), (e >= 1), 2'd0, 1'b0);
      chk($sformatf("bp.ovf.e%0d", e), 32'(ovf_o), 32'(e >= 12));
    end
    btn_i       = 4'b0000;
    evt_ready_i = 1'b1;
    tick(); chk_evt("bp.e13", 1'b1, 2'd0, 1'b1);
    chk("bp.ovf.e13", 32'(ovf_o), 32'd1);
    tick(); chk_evt("bp.e14", 1'b0, 2'd0, 1'b0);
    chk("bp.ovf.e14", 32'(ovf_o), 32'd1);
    clr_ovf_i = 1'b1;
    tick(); chk("clr.ovf.e15", 32'(ovf_o), 32'd0);
    clr_ovf_i = 1'b0;
    tick(); chk("clr.ovf.e16", 32'(ovf_o), 32'd0);

    // button 3 repeat raised on the same edge its pending repeat is granted
    evt_ready_i = 1'b0;
    btn_i       = 4'b1000;
    for (int e = 0; e <= 15; e++) begin
      tick();
      if (e == 11) evt_ready_i = 1'b1;
      if (e == 13) btn_i = 4'b0000;
      chk_evt($sformatf("sim.e%0d", e), (e >= 1 && e <= 13), 2'd3, (e >= 12));
      chk($sformatf("sim.ovf.e%0d", e), 32'(ovf_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
